// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR phase-frequency detector and its lock monitor.
package cdr_pkg;

  localparam int unsigned PFD_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDn,
    StOvl
  } pfd_state_t;

  typedef logic signed [PFD_CNT_W-1:0] phase_err_t;

  // Charge-pump source is on while pulsing up or during the anti-deadzone overlap.
  function automatic logic drives_up(pfd_state_t st);
    return (st == StUp) || (st == StOvl);
  endfunction

  // Charge-pump sink is on while pulsing down or during the anti-deadzone overlap.
  function automatic logic drives_down(pfd_state_t st);
    return (st == StDn) || (st == StOvl);
  endfunction

endpackage

// File: rtl/pfd_cp_driver_if.sv
// Signal bundle between the PFD and the loop controller / charge pump.
// The locked signal exists only when PFD_CP_DRIVER_LOCK_DET_EN is defined.
interface pfd_cp_driver_if #(
  parameter int unsigned CNT_W = cdr_pkg::PFD_CNT_W
) ();

  logic                    en;
  logic                    ref_edge;
  logic                    fb_edge;
  logic                    up;
  logic                    down;
  logic signed [CNT_W-1:0] phase_err;
  logic                    err_valid;
  logic                    sat;
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
  logic                    locked;
`endif

  modport master (
    output en, ref_edge, fb_edge,
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    input  locked,
`endif
    input  up, down, phase_err, err_valid, sat
  );

  modport slave (
    input  en, ref_edge, fb_edge,
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    output locked,
`endif
    output up, down, phase_err, err_valid, sat
  );

endinterface

// File: rtl/pfd_lock_det.sv
// Lock monitor: counts consecutive in-window comparisons and flags lock.
module pfd_lock_det #(
  parameter int unsigned CNT_W    = cdr_pkg::PFD_CNT_W,
  parameter int unsigned LOCK_WIN = 2,
  parameter int unsigned LOCK_CNT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    err_valid,
  input  logic                    sat,
  input  logic signed [CNT_W-1:0] phase_err,
  output logic                    locked
);

  localparam int unsigned     RunW   = $clog2(LOCK_CNT + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(LOCK_CNT);
  localparam logic [CNT_W-1:0] Win   = CNT_W'(LOCK_WIN);

  logic [CNT_W-1:0] mag;
  logic             in_win;
  logic [RunW-1:0]  run_q, run_d;
  logic             locked_q;

  // Next run length: grow on in-window results, saturate at LOCK_CNT, clear otherwise.
  always_comb begin
    // Magnitude cannot overflow since |phase_err| <= MAX_PULSE < 2**(CNT_W-1).
    mag    = phase_err[CNT_W-1] ? $unsigned(-phase_err) : $unsigned(phase_err);
    in_win = (mag <= Win);
    run_d  = run_q;
    if (!en || sat) begin
      run_d = '0;
    end else if (err_valid) begin
      if (!in_win) begin
        run_d = '0;
      end else if (run_q != RunMax) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Run counter and registered lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      locked_q <= (run_d == RunMax);
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/pfd_cp_driver.sv
// Digital phase-frequency detector driving charge-pump up/down controls.
// Optional lock detector enabled by defining PFD_CP_DRIVER_LOCK_DET_EN.
module pfd_cp_driver
  import cdr_pkg::*;
#(
  parameter int unsigned RST_DLY   = 2,
  parameter int unsigned MAX_PULSE = 64,
  parameter int unsigned CNT_W     = PFD_CNT_W
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
  ,
  parameter int unsigned LOCK_WIN  = 2,
  parameter int unsigned LOCK_CNT  = 16
`endif
) (
  input logic            clk,
  input logic            rst_n,
  pfd_cp_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] DlyCnt   = CNT_W'(RST_DLY);
  // With no overlap window a finished comparison returns straight to idle.
  localparam pfd_state_t       AfterCmp = (RST_DLY == 0) ? StIdle : StOvl;

  pfd_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_ref_q, pend_ref_d;
  logic                    pend_fb_q, pend_fb_d;
  logic                    up_q, down_q;
  logic signed [CNT_W-1:0] err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    sat_q, sat_d;
  logic                    ref_eff, fb_eff;

  // Next-state, pulse counter, pending replay and error reporting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_ref_d  = pend_ref_q;
    pend_fb_d   = pend_fb_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    sat_d       = 1'b0;
    // Strobes held over from the overlap window replay alongside live strobes.
    ref_eff     = bus.ref_edge | pend_ref_q;
    fb_eff      = bus.fb_edge | pend_fb_q;

    if (!bus.en) begin
      state_d    = StIdle;
      cnt_d      = '0;
      pend_ref_d = 1'b0;
      pend_fb_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pend_ref_d = 1'b0;
          pend_fb_d  = 1'b0;
          if (ref_eff && fb_eff) begin
            state_d     = AfterCmp;
            cnt_d       = DlyCnt;
            err_d       = '0;
            err_valid_d = 1'b1;
          end else if (ref_eff) begin
            state_d = StUp;
            cnt_d   = CNT_W'(1);
          end else if (fb_eff) begin
            state_d = StDn;
            cnt_d   = CNT_W'(1);
          end
        end
        StUp: begin
          if (bus.fb_edge) begin
            state_d     = AfterCmp;
            cnt_d       = DlyCnt;
            err_d       = $signed(cnt_q);
            err_valid_d = 1'b1;
          end else if (cnt_q == MaxCnt) begin
            state_d     = StIdle;
            cnt_d       = '0;
            err_d       = $signed(MaxCnt);
            err_valid_d = 1'b1;
            sat_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDn: begin
          if (bus.ref_edge) begin
            state_d     = AfterCmp;
            cnt_d       = DlyCnt;
            err_d       = -$signed(cnt_q);
            err_valid_d = 1'b1;
          end else if (cnt_q == MaxCnt) begin
            state_d     = StIdle;
            cnt_d       = '0;
            err_d       = -$signed(MaxCnt);
            err_valid_d = 1'b1;
            sat_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOvl: begin
          // One-deep capture; repeats of the same strobe are dropped.
          pend_ref_d = pend_ref_q | bus.ref_edge;
          pend_fb_d  = pend_fb_q | bus.fb_edge;
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_ref_q  <= 1'b0;
      pend_fb_q   <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_ref_q  <= pend_ref_d;
      pend_fb_q   <= pend_fb_d;
      up_q        <= drives_up(state_d);
      down_q      <= drives_down(state_d);
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.phase_err = err_q;
  assign bus.err_valid = err_valid_q;
  assign bus.sat       = sat_q;

`ifdef PFD_CP_DRIVER_LOCK_DET_EN
  logic locked;

  pfd_lock_det #(
    .CNT_W   (CNT_W),
    .LOCK_WIN(LOCK_WIN),
    .LOCK_CNT(LOCK_CNT)
  ) u_lock_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .err_valid(err_valid_q),
    .sat      (sat_q),
    .phase_err(err_q),
    .locked   (locked)
  );

  assign bus.locked = locked;
`endif

endmodule

// File: tb/tb_pfd_cp_driver.sv
// Self-checking bench for pfd_cp_driver (lock checks under PFD_CP_DRIVER_LOCK_DET_EN).
module tb_pfd_cp_driver;

  localparam int RST_DLY   = 2;
  localparam int MAX_PULSE = 64;
  localparam int CNT_W     = 8;
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
  localparam int LOCK_WIN  = 2;
  localparam int LOCK_CNT  = 16;
`endif

  // One comparison: leading strobe sampled at s, lagging strobe d cycles later (d<0: none).
  typedef struct packed {
    int s;
    int d;
    bit ref_lead;
  } cmp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_err = 0;
  int   run = 0;
  bit   lock_exp = 1'b0;
  cmp_t cmps[$];
  bit   ref_sched[256];
  bit   fb_sched[256];

  pfd_cp_driver_if #(.CNT_W(CNT_W)) bus ();

  pfd_cp_driver #(
    .RST_DLY  (RST_DLY),
    .MAX_PULSE(MAX_PULSE),
    .CNT_W    (CNT_W)
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    ,
    .LOCK_WIN (LOCK_WIN),
    .LOCK_CNT (LOCK_CNT)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Expected {up, down, err_valid, sat} and error at observation j, from pulse arithmetic.
  function automatic void model(input int j, output logic [3:0] f, output int err);
    int s, d, w;
    bit r;
    f   = '0;
    err = 0;
    foreach (cmps[i]) begin
      s = cmps[i].s;
      d = cmps[i].d;
      r = cmps[i].ref_lead;
      w = (d < 0) ? MAX_PULSE : d;
      if (j > s && j <= s + w) f[r ? 3 : 2] = 1'b1;
      if (d < 0) begin
        if (j == s + w + 1) begin
          f[1:0] = 2'b11;
          err    = r ? w : -w;
        end
      end else begin
        if (j > s + d && j <= s + d + RST_DLY) f[3:2] = 2'b11;
        if (j == s + d + 1) begin
          f[1] = 1'b1;
          err  = r ? d : -d;
        end
      end
    end
  endfunction

  task automatic plain(input int s, input int d, input bit r);
    cmps.push_back('{s: s, d: d, ref_lead: r});
    if (r) ref_sched[s] = 1'b1;
    else   fb_sched[s]  = 1'b1;
    if (d >= 0) begin
      if (r) fb_sched[s + d]  = 1'b1;
      else   ref_sched[s + d] = 1'b1;
    end
  endtask

  task automatic run_scn(input string tag);
    int         len, end_j, e;
    logic [3:0] f;
    len = 0;
    foreach (cmps[i]) begin
      end_j = cmps[i].s + ((cmps[i].d < 0) ? MAX_PULSE + 1 : cmps[i].d + RST_DLY) + 1;
      if (end_j > len) len = end_j;
    end
    for (int k = 0; k < len; k++) begin
      bus.ref_edge = ref_sched[k];
      bus.fb_edge  = fb_sched[k];
      @(posedge clk);
      #1;
      model(k + 1, f, e);
      check({tag, " flags"}, 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(f));
      if (f[1]) begin
        check({tag, " err"}, 32'(bus.phase_err), 32'(e));
        last_err = e;
      end else begin
        check({tag, " hold"}, 32'(bus.phase_err), 32'(last_err));
      end
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
      check({tag, " locked"}, 32'(bus.locked), 32'(lock_exp));
      if (f[1]) begin
        if (!f[0] && e <= LOCK_WIN && e >= -LOCK_WIN) begin
          if (run < LOCK_CNT) run++;
        end else begin
          run = 0;
        end
      end
      lock_exp = (run >= LOCK_CNT);
`endif
    end
    bus.ref_edge = 1'b0;
    bus.fb_edge  = 1'b0;
    cmps.delete();
    foreach (ref_sched[i]) begin
      ref_sched[i] = 1'b0;
      fb_sched[i]  = 1'b0;
    end
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.ref_edge = 1'b0;
    bus.fb_edge  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset flags", 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(0));
    check("reset err", 32'(bus.phase_err), 32'(0));
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    check("reset locked", 32'(bus.locked), 32'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle flags", 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(0));

    plain(0, 5, 1'b1);
    run_scn("ref_lead5");
    plain(0, 3, 1'b0);
    run_scn("fb_lead3");
    plain(0, 0, 1'b1);
    run_scn("coincident");
    plain(0, -1, 1'b1);
    run_scn("sat_up");
    plain(0, -1, 1'b0);
    run_scn("sat_dn");

    // fb in the overlap replays on idle entry; ref 4 cycles after that.
    plain(0, 5, 1'b1);
    fb_sched[7] = 1'b1;
    ref_sched[12] = 1'b1;
    cmps.push_back('{s: 8, d: 4, ref_lead: 1'b0});
    run_scn("pend_fb");

    // Pending fb combines with a live ref on idle entry.
    plain(0, 5, 1'b1);
    fb_sched[7] = 1'b1;
    ref_sched[8] = 1'b1;
    cmps.push_back('{s: 8, d: 0, ref_lead: 1'b1});
    run_scn("pend_or_live");

    // Two refs in the overlap: only one is kept.
    plain(0, 2, 1'b1);
    ref_sched[3] = 1'b1;
    ref_sched[4] = 1'b1;
    fb_sched[8]  = 1'b1;
    cmps.push_back('{s: 5, d: 3, ref_lead: 1'b1});
    run_scn("pend_drop");

    // Disable mid-pulse: truncated, nothing reported, strobes ignored.
    bus.ref_edge = 1'b1;
    @(posedge clk);
    #1;
    bus.ref_edge = 1'b0;
    check("en pre up", 32'(bus.up), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    bus.en      = 1'b0;
    bus.fb_edge = 1'b1;
    @(posedge clk);
    #1;
    bus.fb_edge = 1'b0;
    check("en off flags", 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(0));
    check("en off err", 32'(bus.phase_err), 32'(last_err));
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    check("en off locked", 32'(bus.locked), 32'(0));
    run      = 0;
    lock_exp = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("en off flags2", 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(0));
    bus.en = 1'b1;
    plain(0, 7, 1'b0);
    run_scn("en_recover");

    for (int n = 0; n < 24; n++) begin
      int s, d;
      bit r;
      s = int'($urandom_range(0, 3));
      d = (n % 8 == 7) ? -1 : int'($urandom_range(0, MAX_PULSE - 1));
      r = 1'($urandom_range(0, 1));
      plain(s, d, r);
      run_scn("rand");
    end

    // Asynchronous reset in the middle of an up pulse.
    bus.ref_edge = 1'b1;
    @(posedge clk);
    #1;
    bus.ref_edge = 1'b0;
    @(posedge clk);
    #1;
    check("rst pre up", 32'(bus.up), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst async flags", 32'({bus.up, bus.down, bus.err_valid, bus.sat}), 32'(0));
    check("rst async err", 32'(bus.phase_err), 32'(0));
`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    check("rst async locked", 32'(bus.locked), 32'(0));
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    last_err = 0;
    run      = 0;
    lock_exp = 1'b0;

`ifdef PFD_CP_DRIVER_LOCK_DET_EN
    for (int i = 0; i < 16; i++) plain(5 * i, 1, 1'b1);
    plain(80, 5, 1'b1);
    run_scn("lock");
    check("lock final", 32'(bus.locked), 32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
